wlm_sched: RTL and testbench

Shared-access scheduler for one pipelined word-level Montgomery reducer (`wlm`). It arbitrates round-robin among `NREQ` requesters, issues at most one product `C` per cycle into a single internal `wlm` instance, and tags each issue with its requester index. Results return through a `DEPTH`-entry output FIFO with valid/ready handshake; credit accounting guarantees that no result is ever dropped. It also owns the modulus-high register `qH`, which may be rewritten only while the pipeline is empty.

---
 rtl/wlm_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_wlm_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wlm_sched.sv
// wlm_sched: round-robin shared access to one pipelined word-level
// Montgomery reducer, with credit-checked in-order result FIFO.

package wlm_pkg;
    function automatic int wlm_lat(
        int logq, int logqh, int ff_in, int ff_sum,
        int ff_mul, int ff_sub, int ff_out
    );
        int w;
        int nw;
        w  = logq - logqh;
        nw = (logq + w - 1) / w;
        return ff_in + nw * (ff_sum + ff_mul) + ff_sub + ff_out;
    endfunction
endpackage

module wlm #(
    parameter  int LOGQ    = 32,
    parameter  int LOGQH   = 19,
    parameter  int CORRECT = 1,
    parameter  int FF_IN   = 1,
    parameter  int FF_SUM  = 0,
    parameter  int FF_MUL  = 1,
    parameter  int FF_SUB  = 0,
    parameter  int FF_OUT  = 1,
    localparam int LOGC    = 2 * LOGQ,
    localparam int LOGT    = (CORRECT != 0) ? LOGQ : LOGQ + 1
) (
    input  logic             clk,
    input  logic [LOGQH-1:0] qH,
    input  logic [LOGC-1:0]  C,
    output logic [LOGT-1:0]  T
);
    // q = qH * 2^W + 1, so -q^-1 mod 2^W is all-ones and each word
    // step reduces to x' = (x >> W) + m*qH + (low word != 0).
    localparam int W  = LOGQ - LOGQH;
    localparam int NW = (LOGQ + W - 1) / W;
    localparam int XW = LOGC + 1;
    localparam int PW = W + LOGQH;

    logic [NW:0][XW-1:0] xs;

    if (FF_IN != 0) begin : g_in
        logic [XW-1:0] r;
        always_ff @(posedge clk) r <= XW'(C);
        assign xs[0] = r;
    end else begin : g_in_c
        assign xs[0] = XW'(C);
    end

    for (genvar i = 0; i < NW; i++) begin : g_step
        logic [W-1:0]  xl;
        logic [W-1:0]  m;
        logic [PW-1:0] pc;
        logic [PW-1:0] pr;
        logic [XW-1:0] hc;
        logic [XW-1:0] hr;
        logic [XW-1:0] s;
        logic          cc;
        logic          cr;

        assign xl = xs[i][W-1:0];
        assign m  = -xl;
        assign pc = PW'(m) * PW'(qH);
        assign hc = xs[i] >> W;
        assign cc = |xl;

        if (FF_MUL != 0) begin : g_mul
            always_ff @(posedge clk) begin
                pr <= pc;
                hr <= hc;
                cr <= cc;
            end
        end else begin : g_mul_c
            assign pr = pc;
            assign hr = hc;
            assign cr = cc;
        end

        assign s = hr + XW'(pr) + XW'(cr);

        if (FF_SUM != 0) begin : g_sum
            logic [XW-1:0] r;
            always_ff @(posedge clk) r <= s;
            assign xs[i+1] = r;
        end else begin : g_sum_c
            assign xs[i+1] = s;
        end
    end

    logic [XW-1:0]   qf;
    logic [XW-1:0]   dc;
    logic [XW-1:0]   dr;
    logic [LOGT-1:0] tc;

    assign qf = XW'({qH, {(W-1){1'b0}}, 1'b1});
    assign dc = (CORRECT != 0 && xs[NW] >= qf) ? xs[NW] - qf : xs[NW];

    if (FF_SUB != 0) begin : g_sub
        always_ff @(posedge clk) dr <= dc;
    end else begin : g_sub_c
        assign dr = dc;
    end

    assign tc = dr[LOGT-1:0];

    if (FF_OUT != 0) begin : g_out
        always_ff @(posedge clk) T <= tc;
    end else begin : g_out_c
        assign T = tc;
    end
endmodule

module wlm_sched #(
    parameter  int NREQ    = 4,
    parameter  int LOGQ    = 32,
    parameter  int LOGQH   = 19,
    parameter  int CORRECT = 1,
    parameter  int FF_IN   = 1,
    parameter  int FF_SUM  = 0,
    parameter  int FF_MUL  = 1,
    parameter  int FF_SUB  = 0,
    parameter  int FF_OUT  = 1,
    parameter  int DEPTH   = wlm_pkg::wlm_lat(LOGQ, LOGQH, FF_IN,
                             FF_SUM, FF_MUL, FF_SUB, FF_OUT) + 2,
    localparam int LOGC    = 2 * LOGQ,
    localparam int LOGT    = (CORRECT != 0) ? LOGQ : LOGQ + 1,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [LOGQH-1:0]     cfg_qH,
    output logic                 busy,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*LOGC-1:0] req_C,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    output logic [LOGT-1:0]      res_T,
    output logic [IDW-1:0]       res_id,
    input  logic                 res_ready
);
    import wlm_pkg::*;

    localparam int LAT = wlm_lat(LOGQ, LOGQH, FF_IN, FF_SUM,
                                 FF_MUL, FF_SUB, FF_OUT);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gid;
    logic             issue;
    logic             pop;
    logic [CW-1:0]    cnt;
    logic [LOGQH-1:0] qh;
    logic [LOGC-1:0]  c_in;
    logic [LOGT-1:0]  w_t;
    logic             tail_v;
    logic [IDW-1:0]   tail_id;

    logic [LOGT-1:0]  mem_t  [DEPTH];
    logic [IDW-1:0]   mem_id [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    fcnt;

    // Same-cycle pops are deliberately not credited back here.
    always_comb begin
        req_ready = '0;
        gid       = '0;
        issue     = 1'b0;
        if (rst_n && cnt < CW'(DEPTH) && !cfg_we) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!issue && req_valid[(int'(ptr) + k) % NREQ]) begin
                    issue = 1'b1;
                    gid   = IDW'((int'(ptr) + k) % NREQ);
                end
            end
            req_ready[gid] = issue;
        end
    end

    assign c_in = issue ? req_C[int'(gid)*LOGC +: LOGC] : '0;

    wlm #(
        .LOGQ   (LOGQ),
        .LOGQH  (LOGQH),
        .CORRECT(CORRECT),
        .FF_IN  (FF_IN),
        .FF_SUM (FF_SUM),
        .FF_MUL (FF_MUL),
        .FF_SUB (FF_SUB),
        .FF_OUT (FF_OUT)
    ) u_wlm (
        .clk(clk),
        .qH (qh),
        .C  (c_in),
        .T  (w_t)
    );

    if (LAT > 0) begin : g_tag
        logic [LAT-1:0] sv;
        logic [IDW-1:0] sid [LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sv <= '0;
            else        sv <= LAT'({sv, issue});
        end

        always_ff @(posedge clk) begin
            sid[0] <= gid;
            for (int j = 1; j < LAT; j++) sid[j] <= sid[j-1];
        end

        assign tail_v  = sv[LAT-1];
        assign tail_id = sid[LAT-1];
    end else begin : g_tag_c
        assign tail_v  = issue;
        assign tail_id = gid;
    end

    assign res_valid = (fcnt != '0);
    assign pop       = res_valid & res_ready;
    assign res_T     = res_valid ? mem_t[rp]  : '0;
    assign res_id    = res_valid ? mem_id[rp] : '0;
    assign busy      = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= IDW'(NREQ - 1);
            cnt  <= '0;
            qh   <= '0;
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            cnt  <= cnt + CW'(issue) - CW'(pop);
            fcnt <= fcnt + CW'(tail_v) - CW'(pop);
            if (issue) ptr <= gid;
            if (cfg_we && cnt == '0) qh <= cfg_qH;
            if (tail_v) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop)    rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tail_v) begin
            mem_t[wp]  <= w_t;
            mem_id[wp] <= tail_id;
        end
    end
endmodule

// File: tb/tb_wlm_sched.sv
// tb_wlm_sched: vector table, directed corner sequences and random
// traffic checked against a queue-based Montgomery REDC model.

module tb_wlm_sched;
    localparam int NREQ   = 4;
    localparam int LOGQ   = 32;
    localparam int LOGQH  = 19;
    localparam int FF_IN  = 1;
    localparam int FF_SUM = 0;
    localparam int FF_MUL = 1;
    localparam int FF_SUB = 0;
    localparam int FF_OUT = 1;
    localparam int W      = LOGQ - LOGQH;
    localparam int NW     = (LOGQ + W - 1) / W;
    localparam int LAT    = FF_IN + NW * (FF_SUM + FF_MUL)
                            + FF_SUB + FF_OUT;
    localparam int DEPTH  = LAT + 2;
    localparam int RB     = NW * W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_we;
    logic [18:0]  cfg_qH;
    logic         busy;
    logic [3:0]   req_valid;
    logic [255:0] req_C;
    logic [3:0]   req_ready;
    logic         res_valid;
    logic [31:0]  res_T;
    logic [1:0]   res_id;
    logic         res_ready;

    logic         d1_busy;
    logic [3:0]   d1_rv;
    logic [255:0] d1_C;
    logic [3:0]   d1_rdy;
    logic         d1_res_valid;
    logic [31:0]  d1_res_T;
    logic [1:0]   d1_res_id;
    logic         d1_res_ready;

    always #5 clk = ~clk;

    wlm_sched #(.NREQ(NREQ)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_qH   (cfg_qH),
        .busy     (busy),
        .req_valid(req_valid),
        .req_C    (req_C),
        .req_ready(req_ready),
        .res_valid(res_valid),
        .res_T    (res_T),
        .res_id   (res_id),
        .res_ready(res_ready)
    );

    wlm_sched #(.NREQ(NREQ), .DEPTH(1)) u_d1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (1'b0),
        .cfg_qH   (19'h0),
        .busy     (d1_busy),
        .req_valid(d1_rv),
        .req_C    (d1_C),
        .req_ready(d1_rdy),
        .res_valid(d1_res_valid),
        .res_T    (d1_res_T),
        .res_id   (d1_res_id),
        .res_ready(d1_res_ready)
    );

    typedef struct {
        logic [1:0]  id;
        logic [31:0] t;
        int          due;
    } exp_t;

    typedef struct {
        logic [3:0] rv;
        logic       cfg;
        logic [3:0] er;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_g = NREQ - 1;
    logic [18:0] qh_m = '0;
    exp_t        expq[$];
    logic [3:0]  seen_g;
    logic        seen_pop;

    // Full-width REDC: T = (C + M*q) / 2^RB, M = -C*q^-1 mod 2^RB.
    function automatic logic [31:0] ref_t(
        input logic [18:0] qh, input logic [63:0] c
    );
        logic [127:0] q;
        logic [127:0] msk;
        logic [127:0] inv;
        logic [127:0] m;
        logic [127:0] t;
        q   = ({109'b0, qh} << W) + 128'd1;
        msk = (128'd1 << RB) - 128'd1;
        inv = 128'd1;
        for (int i = 0; i < 6; i++)
            inv = (inv * (128'd2 - q * inv)) & msk;
        m = ((~{64'b0, c} + 128'd1) * inv) & msk;
        t = ({64'b0, c} + m * q) >> RB;
        if (t >= q) t = t - q;
        return t[31:0];
    endfunction

    task automatic chk(
        input string nm, input logic [63:0] act, input logic [63:0] want
    );
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    task automatic rand_c();
        for (int i = 0; i < NREQ; i++)
            req_C[i*64 +: 64] = {$urandom, $urandom};
    endtask

    task automatic step();
        logic [3:0] eg;
        int         gsel;
        logic       hv;
        logic [18:0] qh_use;
        @(negedge clk);
        eg   = '0;
        gsel = -1;
        if (rst_n && expq.size() < DEPTH && !cfg_we)
            for (int k = 1; k <= NREQ; k++)
                if (gsel < 0 && req_valid[(last_g + k) % NREQ])
                    gsel = (last_g + k) % NREQ;
        if (gsel >= 0) eg[gsel] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(eg));
        hv = expq.size() > 0 && expq[0].due <= cyc;
        chk("res_valid", 64'(res_valid), 64'(hv));
        if (hv) begin
            chk("res_T", 64'(res_T), 64'(expq[0].t));
            chk("res_id", 64'(res_id), 64'(expq[0].id));
        end
        chk("busy", 64'(busy), 64'(expq.size() != 0));
        seen_g   = req_ready;
        seen_pop = hv && res_ready;
        qh_use   = qh_m;
        if (cfg_we && expq.size() == 0) qh_m = cfg_qH;
        if (seen_pop) void'(expq.pop_front());
        if (gsel >= 0) begin
            expq.push_back('{2'(gsel),
                ref_t(qh_use, req_C[gsel*64 +: 64]), cyc + LAT + 1});
            last_g = gsel;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        req_valid = '0;
        cfg_we    = 1'b0;
        res_ready = 1'b1;
        for (int n = 0; n < 60 && expq.size() != 0; n++) step();
        chk("drain_busy", 64'(busy), 64'(0));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_res_T", 64'(res_T), 64'(0));
        chk("rst_res_id", 64'(res_id), 64'(0));
        expq.delete();
        last_g = NREQ - 1;
        qh_m   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    vec_t tbl[12];
    int   k0;
    int   cnt_g;
    int   cnt_p;
    int   gc[$];
    int   rc[$];
    logic [63:0] d1_c0;

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[2]  = '{4'b0000, 1'b0, 4'b0000};
        tbl[3]  = '{4'b1001, 1'b0, 4'b1000};
        tbl[4]  = '{4'b1001, 1'b0, 4'b0001};
        tbl[5]  = '{4'b0110, 1'b0, 4'b0010};
        tbl[6]  = '{4'b0001, 1'b0, 4'b0001};
        tbl[7]  = '{4'b0011, 1'b0, 4'b0010};
        tbl[8]  = '{4'b0011, 1'b0, 4'b0001};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0000};
        tbl[10] = '{4'b1111, 1'b0, 4'b0010};
        tbl[11] = '{4'b0100, 1'b0, 4'b0100};

        rst_n        = 1'b0;
        cfg_we       = 1'b0;
        cfg_qH       = '0;
        req_valid    = 4'b1111;
        req_C        = '0;
        res_ready    = 1'b1;
        d1_rv        = '0;
        d1_C         = '0;
        d1_res_ready = 1'b1;
        #2;
        chk("init_res_valid", 64'(res_valid), 64'(0));
        chk("init_res_T", 64'(res_T), 64'(0));
        chk("init_res_id", 64'(res_id), 64'(0));
        chk("init_busy", 64'(busy), 64'(0));
        chk("init_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;

        // single zero request from requester 2 with qH = 1
        cfg_we = 1'b1;
        cfg_qH = 19'h1;
        step();
        cfg_we    = 1'b0;
        req_valid = 4'b0100;
        req_C     = '0;
        #1;
        chk("single_grant", 64'(req_ready), 64'(4'b0100));
        step();
        req_valid = '0;
        repeat (LAT - 1) step();
        chk("single_early", 64'(res_valid), 64'(0));
        step();
        chk("single_valid", 64'(res_valid), 64'(1));
        chk("single_T", 64'(res_T), 64'(0));
        chk("single_id", 64'(res_id), 64'(2));
        drain();

        // arbitration table, continuing from last grant = 2
        cfg_qH = 19'h7;
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].rv;
            cfg_we    = tbl[i].cfg;
            rand_c();
            #1;
            chk("tbl_ready", 64'(req_ready), 64'(tbl[i].er));
            step();
        end
        drain();

        // round robin from reset: 0,1,2,3,0,1,2,3
        pulse_reset();
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_c();
            step();
            chk("rr_order", 64'(seen_g), 64'(4'b0001 << (i % 4)));
        end
        drain();

        // backpressure: exactly DEPTH grants, then full drain
        res_ready = 1'b0;
        req_valid = 4'b0001;
        cnt_g     = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            rand_c();
            step();
            if (seen_g[0]) cnt_g++;
        end
        chk("bp_grants", 64'(cnt_g), 64'(DEPTH));
        chk("bp_blocked", 64'(req_ready), 64'(0));
        req_valid = '0;
        res_ready = 1'b1;
        cnt_p     = 0;
        for (int n = 0; n < 60 && expq.size() != 0; n++) begin
            step();
            if (seen_pop) cnt_p++;
        end
        chk("bp_pops", 64'(cnt_p), 64'(DEPTH));
        chk("bp_busy", 64'(busy), 64'(0));

        // config while busy is ignored and blocks grants
        req_valid = 4'b0001;
        rand_c();
        step();
        req_valid = 4'b1111;
        cfg_we    = 1'b1;
        cfg_qH    = 19'h7;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("cfgbusy_nogrant", 64'(req_ready), 64'(0));
            step();
        end
        drain();
        cfg_we = 1'b1;
        step();
        cfg_we    = 1'b0;
        req_valid = 4'b0010;
        rand_c();
        step();
        drain();

        // reset with 3 issues in flight and 2 results in the FIFO
        res_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            rand_c();
            step();
        end
        req_valid = '0;
        step();
        step();
        chk("pre_rst_valid", 64'(res_valid), 64'(1));
        pulse_reset();
        res_ready = 1'b1;
        repeat (2 * LAT) step();
        req_valid = 4'b1111;
        #1;
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
        step();
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            res_ready = ($urandom % 4) != 0;
            cfg_we    = ($urandom % 12) == 0;
            cfg_qH    = 19'($urandom);
            rand_c();
            step();
        end
        drain();

        // DEPTH = 1: pop is not credited in its own cycle, so the
        // issue period is LAT + 2
        d1_c0        = {$urandom, $urandom};
        d1_C         = '0;
        d1_C[63:0]   = d1_c0;
        d1_rv        = 4'b0001;
        d1_res_ready = 1'b1;
        for (int n = 0; n < 6 * (LAT + 2); n++) begin
            @(negedge clk);
            if (d1_rdy[0]) gc.push_back(n);
            if (d1_res_valid) begin
                rc.push_back(n);
                chk("d1_id", 64'(d1_res_id), 64'(0));
                chk("d1_T", 64'(d1_res_T), 64'(ref_t('0, d1_c0)));
            end
            @(posedge clk);
            #1;
        end
        chk("d1_grants", 64'(gc.size()), 64'(6));
        chk("d1_results", 64'(rc.size()), 64'(6));
        for (int j = 1; j < gc.size(); j++)
            chk("d1_period", 64'(gc[j] - gc[j-1]), 64'(LAT + 2));
        k0 = (rc.size() < gc.size()) ? rc.size() : gc.size();
        for (int j = 0; j < k0; j++)
            chk("d1_latency", 64'(rc[j] - gc[j]), 64'(LAT + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
